// File: rtl/findlength_rr_sched.sv
// -----------------------------------------------------------------------------
// findlength_rr_sched
//
// Shares one serial leading-one scanner between N_REQ requesters. Requesters
// are granted in round-robin order; the granted word is captured and scanned
// MSB-first, one bit per clock. The index of the highest set bit (or a
// not-found flag) is presented on a valid/ready result port.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-low reset
//   req_i        per-requester request level
//   data_i       requester k's word in bits [k*W +: W]
//   gnt_o        one-hot, single-cycle grant pulse (first SCAN cycle)
//   busy_o       high while scanning or holding a result
//   res_valid_o  result valid
//   res_ready_i  result consumer ready
//   res_id_o     id of the served requester
//   res_idx_o    index of the highest set bit (0 if none)
//   res_found_o  1 if any bit of the word was set
// -----------------------------------------------------------------------------
module findlength_rr_sched #(
  parameter  int N_REQ = 4,
  parameter  int W     = 16,
  localparam int IW    = $clog2(W),
  localparam int RW    = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*W-1:0] data_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               busy_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [RW-1:0]      res_id_o,
  output logic [IW-1:0]      res_idx_o,
  output logic               res_found_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [W-1:0]     word;
  logic [IW-1:0]    idx;
  logic [RW-1:0]    cur_id;
  logic [RW-1:0]    last_id;
  logic [N_REQ-1:0] gnt;
  logic [RW-1:0]    res_id;
  logic [IW-1:0]    res_idx;
  logic             res_found;

  logic             arb_hit;
  logic [RW-1:0]    arb_id;
  logic [RW-1:0]    cand;
  logic [W-1:0]     sel_word;
  logic             bit_hit;
  logic             scan_last;

  // Round-robin pick: first requester at or after last_id+1, wrapping. The
  // modulo keeps non-power-of-two N_REQ correct.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    arb_hit = 1'b0;
    arb_id  = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = RW'((int'(last_id) + i) % N_REQ);
      if (!arb_hit && req_i[cand]) begin
        arb_hit = 1'b1;
        arb_id  = cand;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_id == RW'(k)) sel_word = data_i[k*W +: W];
    end
  end

  assign bit_hit   = word[idx];
  assign scan_last = bit_hit || (idx == '0);

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_i) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (arb_hit)     state_next = S_SCAN;
      S_SCAN:  if (scan_last)   state_next = S_RESP;
      S_RESP:  if (res_ready_i) state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on grant, walk the index down, latch the result.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      word      <= '0;
      idx       <= '0;
      cur_id    <= '0;
      last_id   <= RW'(N_REQ - 1);
      gnt       <= '0;
      res_id    <= '0;
      res_idx   <= '0;
      res_found <= 1'b0;
    end else begin
      gnt <= '0;
      unique case (state)
        S_IDLE: begin
          if (arb_hit) begin
            word   <= sel_word;
            cur_id <= arb_id;
            idx    <= IW'(W - 1);
            gnt    <= N_REQ'(1) << arb_id;
          end
        end
        S_SCAN: begin
          if (scan_last) begin
            // Found at idx, or exhausted at idx 0 with nothing set.
            res_idx   <= idx;
            res_found <= bit_hit;
            res_id    <= cur_id;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        S_RESP: begin
          if (res_ready_i) begin
            last_id   <= cur_id;
            res_id    <= '0;
            res_idx   <= '0;
            res_found <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    gnt_o       = gnt;
    busy_o      = (state != S_IDLE);
    res_valid_o = (state == S_RESP);
    res_id_o    = res_id;
    res_idx_o   = res_idx;
    res_found_o = res_found;
  end

endmodule

// File: tb/tb_findlength_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_findlength_rr_sched
//
// Directed bench for findlength_rr_sched: a table of single-request scans,
// then hand-written sequences for round-robin order, result backpressure,
// post-grant data changes and reset in the middle of a scan.
// -----------------------------------------------------------------------------
module tb_findlength_rr_sched;

  localparam int N_REQ = 4;
  localparam int W     = 16;

  logic               clk;
  logic               rst_i;
  logic [N_REQ-1:0]   req_i;
  logic [N_REQ*W-1:0] data_i;
  logic [N_REQ-1:0]   gnt_o;
  logic               busy_o;
  logic               res_valid_o;
  logic               res_ready_i;
  logic [1:0]         res_id_o;
  logic [3:0]         res_idx_o;
  logic               res_found_o;

  int n_checks = 0;
  int n_fail   = 0;

  findlength_rr_sched #(.N_REQ(N_REQ), .W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .data_i      (data_i),
    .gnt_o       (gnt_o),
    .busy_o      (busy_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_id_o    (res_id_o),
    .res_idx_o   (res_idx_o),
    .res_found_o (res_found_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          id;
    logic [15:0] word;
    int          exp_scan;
    logic [3:0]  exp_idx;
    logic        exp_found;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b0;
    req_i       = '0;
    res_ready_i = 1'b1;
    step();
    step();
    rst_i = 1'b1;
  endtask

  // Steps until a grant pulse is seen, at most 40 cycles.
  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt_o != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Steps until res_valid_o, at most 64 cycles; n counts the steps taken.
  task automatic wait_valid(output logic ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      n++;
      if (res_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    int   n;
    int   gap;
    logic got;

    vecs[0] = '{id: 0, word: 16'h0100, exp_scan: 8,  exp_idx: 4'd8,  exp_found: 1'b1};
    vecs[1] = '{id: 0, word: 16'h8000, exp_scan: 1,  exp_idx: 4'd15, exp_found: 1'b1};
    vecs[2] = '{id: 0, word: 16'h0000, exp_scan: 16, exp_idx: 4'd0,  exp_found: 1'b0};
    vecs[3] = '{id: 0, word: 16'h0001, exp_scan: 16, exp_idx: 4'd0,  exp_found: 1'b1};
    vecs[4] = '{id: 3, word: 16'h0003, exp_scan: 15, exp_idx: 4'd1,  exp_found: 1'b1};
    vecs[5] = '{id: 1, word: 16'h0020, exp_scan: 11, exp_idx: 4'd5,  exp_found: 1'b1};

    rst_i       = 1'b0;
    req_i       = '0;
    data_i      = '0;
    res_ready_i = 1'b1;

    // ---- reset state ----
    step();
    step();
    check("reset_outputs",
          64'({gnt_o, busy_o, res_valid_o, res_id_o, res_idx_o, res_found_o}), 64'(0));
    rst_i = 1'b1;
    step();
    check("idle_no_req",
          64'({gnt_o, busy_o, res_valid_o, res_id_o, res_idx_o, res_found_o}), 64'(0));

    // ---- table: single requester scans ----
    for (int v = 0; v < 6; v++) begin
      req_i       = N_REQ'(1) << vecs[v].id;
      data_i      = {N_REQ{vecs[v].word}};
      res_ready_i = 1'b1;
      wait_gnt(ok);
      check($sformatf("v%0d_gnt_seen", v), 64'(ok), 64'(1));
      check($sformatf("v%0d_gnt", v), 64'(gnt_o), 64'(N_REQ'(1) << vecs[v].id));
      req_i = '0;
      wait_valid(ok, n);
      check($sformatf("v%0d_valid_seen", v), 64'(ok), 64'(1));
      check($sformatf("v%0d_scan_cycles", v), 64'(n), 64'(vecs[v].exp_scan));
      check($sformatf("v%0d_result", v),
            64'({res_id_o, res_idx_o, res_found_o}),
            64'({2'(vecs[v].id), vecs[v].exp_idx, vecs[v].exp_found}));
      step();
      check($sformatf("v%0d_back_idle", v), 64'({busy_o, res_valid_o}), 64'(0));
    end

    // ---- round robin, all requesting continuously ----
    do_reset();
    data_i = {N_REQ{16'h0010}};
    req_i  = 4'b1111;
    wait_gnt(ok);
    check("rr_first_gnt_seen", 64'(ok), 64'(1));
    for (int t = 0; t < 5; t++) begin
      check($sformatf("rr%0d_gnt", t), 64'(gnt_o), 64'(N_REQ'(1) << (t % N_REQ)));
      wait_valid(ok, n);
      check($sformatf("rr%0d_valid_seen", t), 64'(ok), 64'(1));
      check($sformatf("rr%0d_result", t),
            64'({res_id_o, res_idx_o, res_found_o}),
            64'({2'(t % N_REQ), 4'd4, 1'b1}));
      if (t < 4) begin
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
          step();
          if (gnt_o != '0) begin
            got = 1'b1;
            break;
          end
          if (!busy_o) gap++;
        end
        check($sformatf("rr%0d_idle_gap", t), 64'({got, 8'(gap)}), 64'({1'b1, 8'd1}));
      end
    end

    // ---- backpressure, then post-grant data change ----
    do_reset();
    data_i      = {16'h0000, 16'h0400, 16'h0002, 16'h4000};
    req_i       = 4'b0001;
    res_ready_i = 1'b0;
    wait_gnt(ok);
    check("bp_gnt0", 64'({ok, gnt_o}), 64'({1'b1, 4'b0001}));
    req_i = 4'b0110;
    wait_valid(ok, n);
    check("bp_first_result",
          64'({ok, 8'(n), res_id_o, res_idx_o, res_found_o}),
          64'({1'b1, 8'd2, 2'd0, 4'd14, 1'b1}));
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold%0d", i),
            64'({res_valid_o, busy_o, gnt_o, res_id_o, res_idx_o, res_found_o}),
            64'({1'b1, 1'b1, 4'b0000, 2'd0, 4'd14, 1'b1}));
    end
    res_ready_i = 1'b1;
    wait_gnt(ok);
    check("bp_next_gnt1", 64'({ok, gnt_o}), 64'({1'b1, 4'b0010}));
    req_i = 4'b0100;
    wait_valid(ok, n);
    check("bp_result1",
          64'({ok, 8'(n), res_id_o, res_idx_o, res_found_o}),
          64'({1'b1, 8'd15, 2'd1, 4'd1, 1'b1}));
    wait_gnt(ok);
    check("dc_gnt2", 64'({ok, gnt_o}), 64'({1'b1, 4'b0100}));
    data_i[2*W +: W] = 16'hFFFF;
    req_i = '0;
    wait_valid(ok, n);
    check("dc_result2",
          64'({ok, 8'(n), res_id_o, res_idx_o, res_found_o}),
          64'({1'b1, 8'd6, 2'd2, 4'd10, 1'b1}));

    // ---- reset in the middle of a scan ----
    do_reset();
    data_i = {16'h0001, 16'h0000, 16'h0000, 16'h0100};
    req_i  = 4'b1000;
    wait_gnt(ok);
    check("rs_gnt3", 64'({ok, gnt_o}), 64'({1'b1, 4'b1000}));
    step();
    step();
    step();
    check("rs_mid_scan", 64'({busy_o, res_valid_o}), 64'({1'b1, 1'b0}));
    rst_i = 1'b0;
    req_i = 4'b1001;
    step();
    check("rs_after_reset",
          64'({gnt_o, busy_o, res_valid_o, res_id_o, res_idx_o, res_found_o}), 64'(0));
    rst_i = 1'b1;
    wait_gnt(ok);
    check("rs_gnt0_first", 64'({ok, gnt_o}), 64'({1'b1, 4'b0001}));
    req_i = 4'b1000;
    wait_valid(ok, n);
    check("rs_result0",
          64'({ok, 8'(n), res_id_o, res_idx_o, res_found_o}),
          64'({1'b1, 8'd8, 2'd0, 4'd8, 1'b1}));
    req_i = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
